// File: rtl/booth_mult_vr.sv
// Sequential radix-2 Booth multiplier with valid/ready handshakes on both sides.
// Operands are widened by one bit so one datapath covers signed and unsigned modes.
module booth_mult_vr #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 signed_mode,
    input  logic                 src_valid,
    output logic                 src_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 dst_valid,
    input  logic                 dst_ready
);

    localparam int unsigned XW = WIDTH + 1;
    localparam int unsigned CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [XW-1:0]   acc;
    logic [XW-1:0]   q;
    logic [XW-1:0]   m;
    logic            q_m1;
    logic [CW-1:0]   cnt;

    logic [XW-1:0]   sum;
    logic [XW-1:0]   acc_nx;
    logic [XW-1:0]   q_nx;
    logic [2*XW-1:0] prod_full;

    // One Booth step: add/subtract M, then arithmetic shift {A, Q, Q(-1)} right.
    always_comb begin
        sum = acc;
        case ({q[0], q_m1})
            2'b01:   sum = acc + m;
            2'b10:   sum = acc - m;
            default: sum = acc;
        endcase
        acc_nx    = {sum[XW-1], sum[XW-1:1]};
        q_nx      = {sum[0], q[XW-1:1]};
        prod_full = {acc_nx, q_nx};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            q         <= '0;
            m         <= '0;
            q_m1      <= 1'b0;
            cnt       <= '0;
            product   <= '0;
            src_ready <= 1'b1;
            dst_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (src_valid) begin
                        m         <= {signed_mode & multiplicand[WIDTH-1], multiplicand};
                        q         <= {signed_mode & multiplier[WIDTH-1], multiplier};
                        acc       <= '0;
                        q_m1      <= 1'b0;
                        cnt       <= '0;
                        src_ready <= 1'b0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    acc  <= acc_nx;
                    q    <= q_nx;
                    q_m1 <= q[0];
                    cnt  <= cnt + CW'(1);
                    // The (WIDTH+1)-th step is the last one for a (WIDTH+1)-bit multiplier.
                    if (cnt == CW'(WIDTH)) begin
                        product   <= prod_full[2*WIDTH-1:0];
                        dst_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (dst_ready) begin
                        dst_valid <= 1'b0;
                        src_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_vr.sv
// Directed bench for booth_mult_vr at WIDTH 16, 4 and 32.
module tb_booth_mult_vr;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [15:0] m16 = '0, q16 = '0;
    logic        sm16 = 1'b0, sv16 = 1'b0, dr16 = 1'b0, sr16, dv16;
    logic [31:0] p16;
    logic [3:0]  m4 = '0, q4 = '0;
    logic        sm4 = 1'b0, sv4 = 1'b0, dr4 = 1'b0, sr4, dv4;
    logic [7:0]  p4;
    logic [31:0] m32 = '0, q32 = '0;
    logic        sm32 = 1'b0, sv32 = 1'b0, dr32 = 1'b0, sr32, dv32;
    logic [63:0] p32;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    booth_mult_vr #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .multiplicand(m16), .multiplier(q16), .signed_mode(sm16),
        .src_valid(sv16), .src_ready(sr16), .product(p16), .dst_valid(dv16), .dst_ready(dr16));
    booth_mult_vr #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .multiplicand(m4), .multiplier(q4), .signed_mode(sm4),
        .src_valid(sv4), .src_ready(sr4), .product(p4), .dst_valid(dv4), .dst_ready(dr4));
    booth_mult_vr #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .multiplicand(m32), .multiplier(q32), .signed_mode(sm32),
        .src_valid(sv32), .src_ready(sr32), .product(p32), .dst_valid(dv32), .dst_ready(dr32));

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic dv_of(input int w);
        case (w)
            4:       return dv4;
            32:      return dv32;
            default: return dv16;
        endcase
    endfunction

    function automatic logic sr_of(input int w);
        case (w)
            4:       return sr4;
            32:      return sr32;
            default: return sr16;
        endcase
    endfunction

    function automatic logic [63:0] prod_of(input int w);
        case (w)
            4:       return 64'(p4);
            32:      return p32;
            default: return 64'(p16);
        endcase
    endfunction

    task automatic drive(input int w, input logic [31:0] mv, input logic [31:0] qv,
                         input logic sm, input logic v);
        case (w)
            4:       begin m4 = mv[3:0]; q4 = qv[3:0]; sm4 = sm; sv4 = v; end
            32:      begin m32 = mv; q32 = qv; sm32 = sm; sv32 = v; end
            default: begin m16 = mv[15:0]; q16 = qv[15:0]; sm16 = sm; sv16 = v; end
        endcase
    endtask

    task automatic set_dr(input int w, input logic r);
        case (w)
            4:       dr4 = r;
            32:      dr32 = r;
            default: dr16 = r;
        endcase
    endtask

    function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a,
                                            input logic [31:0] b, input logic sm);
        logic signed [63:0] sa, sb, pr;
        logic [63:0] mask;
        sa = 64'(a);
        sb = 64'(b);
        if (sm) begin
            sa = sa <<< (64 - w); sa = sa >>> (64 - w);
            sb = sb <<< (64 - w); sb = sb >>> (64 - w);
        end
        pr   = sa * sb;
        mask = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
        return pr & mask;
    endfunction

    // One full transaction; operands are scrambled right after acceptance.
    task automatic op(input int w, input logic [31:0] mv, input logic [31:0] qv,
                      input logic sm, input logic [63:0] exp, input string tag, input int hold);
        int lat;
        chk(64'(sr_of(w)), 64'd1, {tag, " src_ready before accept"});
        drive(w, mv, qv, sm, 1'b1);
        @(posedge clk); #1;
        drive(w, ~mv, ~qv, ~sm, 1'b0);
        lat = 0;
        while (!dv_of(w) && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk(64'(lat), 64'(w + 1), {tag, " latency"});
        chk(prod_of(w), exp, {tag, " product"});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk(prod_of(w), exp, {tag, " held product"});
            chk(64'(dv_of(w)), 64'd1, {tag, " held dst_valid"});
            chk(64'(sr_of(w)), 64'd0, {tag, " held src_ready"});
        end
        set_dr(w, 1'b1);
        @(posedge clk); #1;
        set_dr(w, 1'b0);
        chk(64'(dv_of(w)), 64'd0, {tag, " dst_valid after accept"});
        chk(64'(sr_of(w)), 64'd1, {tag, " src_ready after accept"});
    endtask

    initial begin
        int lat;
        int t [4];
        logic [31:0] a, b;
        logic [63:0] exp;

        // Reset state
        #12;
        chk(64'(sr16), 64'd1, "rst src_ready");
        chk(64'(dv16), 64'd0, "rst dst_valid");
        chk(64'(p16), 64'd0, "rst product");
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk(64'(sr16), 64'd1, "post-rst src_ready");
        chk(64'(dv16), 64'd0, "post-rst dst_valid");

        // Signed/unsigned directed cases, with backpressure on the first
        op(16, 32'hFFFD, 32'h0005, 1'b1, 64'hFFFFFFF1, "s16 -3x5", 10);
        op(16, 32'hFFFF, 32'hFFFF, 1'b0, 64'hFFFE0001, "u16 ffff^2", 0);
        op(16, 32'hFFFF, 32'hFFFF, 1'b1, 64'h00000001, "s16 -1x-1", 0);
        op(16, 32'h8000, 32'h8000, 1'b1, 64'h40000000, "s16 min^2", 0);

        // Reset mid-operation at step 8
        drive(16, 32'h1234, 32'h5678, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(16, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk(64'(sr16), 64'd1, "midrst src_ready");
        chk(64'(dv16), 64'd0, "midrst dst_valid");
        chk(64'(p16), 64'd0, "midrst product");
        #1 rst = 1'b0;
        @(posedge clk); #1;
        op(16, 32'd7, 32'd9, 1'b0, 64'h3F, "u16 7x9 after rst", 0);

        // Back-to-back stream with src_valid and dst_ready held high
        dr16 = 1'b1;
        sv16 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 32'($urandom & 32'hFFFF);
            b = 32'($urandom & 32'hFFFF);
            m16 = a[15:0]; q16 = b[15:0]; sm16 = 1'b1;
            exp = ref_mul(16, a, b, 1'b1);
            lat = 0;
            while (!sr16 && lat < 100) begin
                @(posedge clk); #1;
                lat++;
            end
            @(posedge clk); #1;
            t[i] = cyc;
            m16 = ~m16; q16 = ~q16; sm16 = 1'b0;
            lat = 0;
            while (!dv16 && lat < 100) begin
                @(posedge clk); #1;
                lat++;
            end
            chk(64'(lat), 64'd17, "stream latency");
            chk(64'(p16), exp, "stream product");
            if (i > 0) chk(64'(t[i] - t[i-1]), 64'd19, "stream spacing");
            if (i == 3) sv16 = 1'b0;
        end
        @(posedge clk); #1;
        dr16 = 1'b0;
        chk(64'(sr16), 64'd1, "stream end src_ready");

        // Parameter sweep
        op(4, 32'h8, 32'h7, 1'b1, 64'hC8, "s4 -8x7", 0);
        op(4, 32'hF, 32'hF, 1'b0, 64'hE1, "u4 15x15", 0);
        op(32, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, "u32 max^2", 0);
        op(32, 32'h80000000, 32'h7FFFFFFF, 1'b1, 64'hC000000080000000, "s32 min x max", 0);
        for (int i = 0; i < 4; i++) begin
            a = 32'($urandom & 32'hF);
            b = 32'($urandom & 32'hF);
            op(4, a, b, i[0], ref_mul(4, a, b, i[0]), "rand w4", 0);
            a = $urandom;
            b = $urandom;
            op(32, a, b, i[0], ref_mul(32, a, b, i[0]), "rand w32", 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
